// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM states, {cpol,cpha} mode encodings, default word width.
// Pure declarations; no logic, no latency, no flow control.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DATA_W_DEF = 8;

    // Which sck edge captures miso for a given clock phase.
    function automatic logic is_sample_edge(input logic cpha, input logic leading,
                                            input logic trailing);
        return cpha ? trailing : leading;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// sck divider: tick every CLK_DIV cycles while run is high, leading/trailing edge strobes while edge_en.
// Strobes are combinational from the counter; the toggled sck becomes visible the cycle after a strobe.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic edge_en,
    output logic tick,
    output logic leading,
    output logic trailing
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             phase;

    assign tick     = run && (div_cnt == DIV_LAST);
    assign leading  = tick && edge_en && !phase;
    assign trailing = tick && edge_en && phase;

    // Counter restarts from zero on every accept, so the first edge is always CLK_DIV cycles out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (tick && edge_en)
                phase <= ~phase;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, modes 0-3, one word per start; done at T0+1+CLK_DIV*(2*DATA_W+1). start ignored unless IDLE.
// Bit order is MSB first; define SPI_MASTER_LSB_FIRST_EN for LSB first with identical timing.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    output logic              csn,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    state_t            state;
    logic              cpol_r;
    logic              cpha_r;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic [EW-1:0]     edge_cnt;
    logic              first_bit;
    logic              next_bit;
    logic              run;
    logic              edge_en;
    logic              tick;
    logic              leading;
    logic              trailing;
    logic              sample;
    logic              advance;

    assign run     = (state != IDLE);
    assign edge_en = (state == SETUP) || (state == SHIFT);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .edge_en  (edge_en),
        .tick     (tick),
        .leading  (leading),
        .trailing (trailing)
    );

    always_comb begin
`ifdef SPI_MASTER_LSB_FIRST_EN
        first_bit           = tx_data[0];
        tx_next             = tx_sr >> 1;
        next_bit            = tx_next[0];
        rx_next             = rx_sr >> 1;
        rx_next[DATA_W-1]   = miso;
`else
        first_bit           = tx_data[DATA_W-1];
        tx_next             = tx_sr << 1;
        next_bit            = tx_next[DATA_W-1];
        rx_next             = rx_sr << 1;
        rx_next[0]          = miso;
`endif
    end

    // The first bit is already on mosi from T0+1, so CPHA=1 skips the first leading
    // edge and CPHA=0 has nothing left to shift after the final trailing edge.
    assign sample  = is_sample_edge(cpha_r, leading, trailing);
    assign advance = cpha_r ? (leading && (edge_cnt != '0))
                            : (trailing && (edge_cnt != LAST_EDGE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            csn      <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    csn  <= 1'b1;
                    mosi <= 1'b0;
                    busy <= 1'b0;
                    sck  <= cpol_r;
                    if (start) begin
                        cpol_r   <= cpol;
                        cpha_r   <= cpha;
                        sck      <= cpol;
                        tx_sr    <= tx_data;
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                        mosi     <= first_bit;
                        csn      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    if (leading || trailing) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (sample)
                            rx_sr <= rx_next;
                        if (advance) begin
                            tx_sr <= tx_next;
                            mosi  <= next_bit;
                        end
                        state <= (edge_cnt == LAST_EDGE) ? HOLD : SHIFT;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        csn     <= 1'b1;
                        busy    <= 1'b0;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed mode table, random transfers against a behavioural slave,
// back-to-back, ignored start and mid-transfer reset sequences.
module tb_spi_master;

    localparam int CD  = 4;
    localparam int DW  = 8;
    localparam int LAT = 1 + CD * (2 * DW + 1);
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] rx_data;
    logic          sck;
    logic          mosi;
    logic          csn;
    logic          miso = 1'b0;

    int errors = 0;
    int checks = 0;

    spi_master #(.CLK_DIV(CD), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cpol    (cpol),
        .cpha    (cpha),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sck     (sck),
        .mosi    (mosi),
        .csn     (csn),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic word_bit(input logic [DW-1:0] w, input int i);
        if (i < 0 || i >= DW) return 1'b0;
        return LSB ? w[i] : w[DW-1-i];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural slave: watches sck transitions while selected, shifts its word out and captures mosi.
    logic          s_cpol = 1'b0;
    logic          s_cpha = 1'b0;
    logic [DW-1:0] s_word = '0;
    logic [DW-1:0] s_cap = '0;
    int            s_lead = 0;
    int            s_ncap = 0;
    int            s_bit = 0;
    logic          prev_sck = 1'b0;
    logic          prev_csn = 1'b1;

    always @(negedge clk) begin
        if (csn !== 1'b0) begin
            miso = word_bit(s_word, 0);
        end else if (prev_csn === 1'b1) begin
            s_lead = 0;
            s_ncap = 0;
            s_bit  = 0;
            s_cap  = '0;
        end else if (sck !== prev_sck) begin
            if (sck !== s_cpol) begin
                s_lead++;
                if (s_cpha) begin
                    miso = word_bit(s_word, s_bit);
                    s_bit++;
                end else begin
                    if (s_ncap < DW) s_cap[LSB ? s_ncap : DW-1-s_ncap] = mosi;
                    s_ncap++;
                end
            end else begin
                if (s_cpha) begin
                    if (s_ncap < DW) s_cap[LSB ? s_ncap : DW-1-s_ncap] = mosi;
                    s_ncap++;
                end else begin
                    s_bit++;
                    miso = word_bit(s_word, s_bit);
                end
            end
        end
        prev_sck = sck;
        prev_csn = csn;
    end

    // Called #1 after an accept edge; returns the cycle index (T0 = 0) of the done pulse.
    task automatic wait_done(output int n);
        n = 1;
        while (n < LAT + 40) begin
            @(negedge clk);
            if (done === 1'b1) break;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_xfer(input logic p, input logic h, input logic [DW-1:0] tx,
                           input logic [DW-1:0] sw, input logic [DW-1:0] ecap,
                           input logic [DW-1:0] erx, input int poke_at);
        int n;
        int bad;
        int extra;
        s_cpol = p; s_cpha = h; s_word = sw;
        cpol = p; cpha = h; tx_data = tx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        bad = 0;
        while (n < LAT + 40) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (n == 1) check("mosi_first", {31'd0, mosi}, {31'd0, word_bit(tx, 0)});
            if (csn !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
            n++;
            start = (n == poke_at);
        end
        start = 1'b0;
        check("done_latency", n, LAT);
        check("rx_data", rx_data, erx);
        check("slave_capture", s_cap, ecap);
        check("leading_edges", s_lead, DW);
        check("frame_csn_busy", bad, 0);
        check("busy_in_done", busy, 1'b0);
        @(negedge clk);
        check("idle_after_done", {done, csn, sck}, {1'b0, 1'b1, p});
        if (poke_at > 0) begin
            extra = 0;
            repeat (80) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check("extra_done", extra, 0);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic          p;
        logic          h;
        logic [DW-1:0] tx;
        logic [DW-1:0] sw;
        logic [DW-1:0] exp_cap;
        logic [DW-1:0] exp_rx;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        int seen;
        logic          rp, rh;
        logic [DW-1:0] rtx, rsw;

        tbl[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        tbl[1] = '{1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        tbl[2] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        tbl[3] = '{1'b1, 1'b0, 8'h5A, 8'h96, 8'h5A, 8'h96};
        tbl[4] = '{1'b0, 1'b0, 8'h01, 8'h80, 8'h01, 8'h80};
        tbl[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_csn", csn, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            do_xfer(tbl[i].p, tbl[i].h, tbl[i].tx, tbl[i].sw, tbl[i].exp_cap, tbl[i].exp_rx, 0);

        for (int i = 0; i < 16; i++) begin
            rp  = 1'($urandom_range(0, 1));
            rh  = 1'($urandom_range(0, 1));
            rtx = DW'($urandom);
            rsw = DW'($urandom);
            do_xfer(rp, rh, rtx, rsw, rtx, rsw, 0);
        end

        // A start pulse mid-transfer must not queue a second transfer.
        do_xfer(1'b0, 1'b0, 8'h3E, 8'hE3, 8'h3E, 8'hE3, 10);

        // Back-to-back with start held high across the done cycle.
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'h3C;
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        check("b2b_latency1", n, LAT);
        check("b2b_capture1", s_cap, 8'h11);
        check("b2b_csn_high", csn, 1'b1);
        tx_data = 8'h22;
        @(posedge clk); #1;
        check("b2b_csn_low_again", csn, 1'b0);
        wait_done(n);
        start = 1'b0;
        check("b2b_latency2", n, LAT);
        check("b2b_capture2", s_cap, 8'h22);
        check("b2b_rx_data", rx_data, 8'h3C);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_idle", {csn, busy}, {1'b1, 1'b0});
        @(posedge clk); #1;

        // Reset at T0+30 aborts with no done pulse and clears rx_data.
        s_cpol = 1'b1; s_cpha = 1'b0; s_word = 8'h55;
        cpol = 1'b1; cpha = 1'b0; tx_data = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        repeat (29) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_csn", csn, 1'b1);
        check("abort_sck", sck, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_rx_data", rx_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_xfer(1'b0, 1'b0, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
